// File: rtl/gcc.sv
// Weighted gravity-centre calculator over a sliding three-point window, one result per clock.
// Build option: define GCC_ROUND_EN for round-half-up quotients; the default build truncates.
module gcc #(
    parameter int DW = 8,
    parameter int WW = 4
) (
    input  logic          CLK,
    input  logic          RESET_,
    input  logic [DW-1:0] Xi,
    input  logic [DW-1:0] Yi,
    input  logic [WW-1:0] Wi,
    output logic          READY_,
    output logic [DW-1:0] Xc,
    output logic [DW-1:0] Yc
);

    localparam int PW = DW + WW;   // product width
    localparam int NW = PW + 2;    // numerator width (sum of three products)
    localparam int SW = WW + 2;    // weight-sum width

    logic [DW-1:0] x_p1, y_p1, x_p2, y_p2;
    logic [WW-1:0] w_p1, w_p2;
    logic [1:0]    fill_cnt;

    logic [PW-1:0] px0, px1, px2, py0, py1, py2;
    logic [NW-1:0] num_x, num_y;
    logic [SW-1:0] wsum;

    // Quotient of a window sum; zero total weight yields zero. Saturation guards the rounded form.
    function automatic logic [DW-1:0] quot(input logic [NW-1:0] num, input logic [SW-1:0] den);
        logic [NW:0] n2;
        logic [NW:0] d2;
        logic [NW:0] q;
        if (den == '0) return '0;
`ifdef GCC_ROUND_EN
        n2 = {num, 1'b0} + (NW+1)'(den);
        d2 = (NW+1)'({den, 1'b0});
`else
        n2 = (NW+1)'(num);
        d2 = (NW+1)'(den);
`endif
        q = n2 / d2;
        if (q > (NW+1)'({DW{1'b1}})) return '1;
        return q[DW-1:0];
    endfunction

    // Stage p0: incoming point combined with the two stored window points
    assign px0 = {{WW{1'b0}}, Xi}   * {{DW{1'b0}}, Wi};
    assign px1 = {{WW{1'b0}}, x_p1} * {{DW{1'b0}}, w_p1};
    assign px2 = {{WW{1'b0}}, x_p2} * {{DW{1'b0}}, w_p2};
    assign py0 = {{WW{1'b0}}, Yi}   * {{DW{1'b0}}, Wi};
    assign py1 = {{WW{1'b0}}, y_p1} * {{DW{1'b0}}, w_p1};
    assign py2 = {{WW{1'b0}}, y_p2} * {{DW{1'b0}}, w_p2};

    assign num_x = NW'(px0) + NW'(px1) + NW'(px2);
    assign num_y = NW'(py0) + NW'(py1) + NW'(py2);
    assign wsum  = SW'(Wi) + SW'(w_p1) + SW'(w_p2);

    // Stage p1: window shift and registered centroid
    always_ff @(posedge CLK) begin
        if (RESET_) begin
            x_p1     <= '0;
            y_p1     <= '0;
            w_p1     <= '0;
            x_p2     <= '0;
            y_p2     <= '0;
            w_p2     <= '0;
            fill_cnt <= '0;
            READY_   <= 1'b1;
            Xc       <= '0;
            Yc       <= '0;
        end else begin
            x_p1 <= Xi;
            y_p1 <= Yi;
            w_p1 <= Wi;
            x_p2 <= x_p1;
            y_p2 <= y_p1;
            w_p2 <= w_p1;
            if (fill_cnt != 2'd3) fill_cnt <= fill_cnt + 2'd1;
            // Two samples already stored means this edge completes a full window
            if (fill_cnt >= 2'd2) begin
                READY_ <= 1'b0;
                Xc     <= quot(num_x, wsum);
                Yc     <= quot(num_y, wsum);
            end
        end
    end

endmodule

// File: tb/tb_gcc.sv
// Directed and streaming checks for the gcc weighted-centroid block.
module tb_gcc;

    logic       CLK = 1'b0;
    logic       RESET_ = 1'b1;
    logic [7:0] Xi = '0;
    logic [7:0] Yi = '0;
    logic [3:0] Wi = '0;
    logic       READY_;
    logic [7:0] Xc;
    logic [7:0] Yc;

    int checks = 0;
    int failures = 0;

    gcc #(.DW(8), .WW(4)) dut (
        .CLK(CLK), .RESET_(RESET_), .Xi(Xi), .Yi(Yi), .Wi(Wi),
        .READY_(READY_), .Xc(Xc), .Yc(Yc)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_q(input int num, input int den);
        int q;
        if (den == 0) return 0;
`ifdef GCC_ROUND_EN
        q = (2 * num + den) / (2 * den);
        if (q > 255) q = 255;
`else
        q = num / den;
`endif
        return q;
    endfunction

    task automatic push(input int x, input int y, input int w);
        Xi = 8'(x);
        Yi = 8'(y);
        Wi = 4'(w);
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET_ = 1'b1;
        @(posedge CLK);
        #1;
        RESET_ = 1'b0;
    endtask

    task automatic chk_out(input string tag, input int rdy, input int xc, input int yc);
        chk({tag, "_ready"}, int'(READY_), rdy);
        chk({tag, "_xc"}, int'(Xc), xc);
        chk({tag, "_yc"}, int'(Yc), yc);
    endtask

    int wx[3], wy[3], ww[3];
    int fill, exp_rdy, exp_x, exp_y, nx, ny, ns, sx, sy, sw;

    initial begin
        Xi = 8'd77; Yi = 8'd88; Wi = 4'd9;
        do_reset();
        chk_out("reset", 1, 0, 0);

        push(10, 20, 1);  chk_out("basic1", 1, 0, 0);
        push(20, 40, 1);  chk_out("basic2", 1, 0, 0);
        push(30, 60, 1);  chk_out("basic3", 0, 8'h14, 8'h28);

        do_reset();
        push(0, 0, 1);
        push(90, 0, 2);
        push(0, 90, 0);   chk_out("weighted", 0, 60, 0);
        push(0, 90, 3);   chk_out("weighted_next", 0, 36, 54);

        do_reset();
        push(0, 0, 1);
        push(1, 0, 1);
        push(1, 0, 1);
`ifdef GCC_ROUND_EN
        chk_out("round", 0, 1, 0);
`else
        chk_out("trunc", 0, 0, 0);
`endif

        do_reset();
        push(200, 100, 0); chk_out("zero1", 1, 0, 0);
        push(50, 150, 0);  chk_out("zero2", 1, 0, 0);
        push(255, 255, 0); chk_out("zero3", 0, 0, 0);

        push(255, 255, 15);
        push(255, 255, 15);
        push(255, 255, 15); chk_out("max", 0, 255, 255);

        // Mid-stream reset with heavy pre-reset points that would skew a leaked window
        push(200, 200, 15);
        push(200, 200, 15);
        Xi = 8'd240; Yi = 8'd240; Wi = 4'd15;
        do_reset();
        chk_out("midrst", 1, 0, 0);
        push(100, 50, 1); chk_out("post1", 1, 0, 0);
        push(100, 50, 1); chk_out("post2", 1, 0, 0);
        push(100, 50, 1); chk_out("post3", 0, 100, 50);

        // Random stream against a reference window model
        do_reset();
        fill = 0;
        exp_rdy = 1; exp_x = 0; exp_y = 0;
        for (int i = 0; i < 3; i++) begin
            wx[i] = 0; wy[i] = 0; ww[i] = 0;
        end
        for (int i = 0; i < 1200; i++) begin
            nx = $urandom_range(0, 255);
            ny = $urandom_range(0, 255);
            ns = (i % 97 == 13) ? 0 : $urandom_range(0, 15);
            if (fill >= 2) begin
                sx = nx * ns + wx[0] * ww[0] + wx[1] * ww[1];
                sy = ny * ns + wy[0] * ww[0] + wy[1] * ww[1];
                sw = ns + ww[0] + ww[1];
                exp_x = ref_q(sx, sw);
                exp_y = ref_q(sy, sw);
                exp_rdy = 0;
            end
            wx[1] = wx[0]; wy[1] = wy[0]; ww[1] = ww[0];
            wx[0] = nx;    wy[0] = ny;    ww[0] = ns;
            if (fill < 3) fill++;
            push(nx, ny, ns);
            chk_out("stream", exp_rdy, exp_x, exp_y);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
